// File: rtl/prescaler_multi.sv
// Bank of independent programmable clock prescalers. Each channel emits a
// registered divided waveform and a period-start strobe; reloads land on the period boundary.
module prescaler_multi #(
  parameter int CHANNELS   = 2,
  parameter int WIDTH      = 8,
  parameter int RESET_DIV  = 1,
  parameter int RESET_HIGH = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [CHANNELS-1:0]       en_i,
  input  logic [CHANNELS-1:0]       load_i,
  input  logic [CHANNELS*WIDTH-1:0] div_i,
  input  logic [CHANNELS*WIDTH-1:0] high_i,
  output logic [CHANNELS-1:0]       out_clk_o,
  output logic [CHANNELS-1:0]       tick_o,
  output logic [CHANNELS-1:0]       pending_o
);

  logic [CHANNELS-1:0][WIDTH-1:0] divIn, highIn;
  logic [CHANNELS-1:0][WIDTH-1:0] cnt_q, cnt_d;
  logic [CHANNELS-1:0][WIDTH-1:0] divA_q, divA_d, highA_q, highA_d;
  logic [CHANNELS-1:0][WIDTH-1:0] divS_q, divS_d, highS_q, highS_d;
  logic [CHANNELS-1:0]            pending_q, pending_d;
  logic [CHANNELS-1:0]            outClk_q, outClk_d;
  logic [CHANNELS-1:0]            tick_q, tick_d;

  assign divIn  = div_i;
  assign highIn = high_i;

  always_comb begin
    cnt_d     = cnt_q;
    divA_d    = divA_q;
    highA_d   = highA_q;
    divS_d    = divS_q;
    highS_d   = highS_q;
    pending_d = pending_q;
    outClk_d  = outClk_q;
    tick_d    = tick_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!en_i[i]) begin
        cnt_d[i]    = '0;
        outClk_d[i] = 1'b0;
        tick_d[i]   = 1'b0;
        // An idle channel has no period to protect, so loads go straight to the active set.
        if (load_i[i]) begin
          divA_d[i]    = divIn[i];
          highA_d[i]   = highIn[i];
          pending_d[i] = 1'b0;
        end
      end else begin
        outClk_d[i] = (cnt_q[i] < highA_q[i]);
        tick_d[i]   = (cnt_q[i] == '0);
        if (cnt_q[i] == divA_q[i]) begin
          cnt_d[i] = '0;
          // A load coinciding with the wrap is newer than the shadow and takes priority.
          if (load_i[i]) begin
            divA_d[i]    = divIn[i];
            highA_d[i]   = highIn[i];
            pending_d[i] = 1'b0;
          end else if (pending_q[i]) begin
            divA_d[i]    = divS_q[i];
            highA_d[i]   = highS_q[i];
            pending_d[i] = 1'b0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + WIDTH'(1);
          if (load_i[i]) begin
            divS_d[i]    = divIn[i];
            highS_d[i]   = highIn[i];
            pending_d[i] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q     <= '0;
      divA_q    <= {CHANNELS{WIDTH'(RESET_DIV)}};
      highA_q   <= {CHANNELS{WIDTH'(RESET_HIGH)}};
      divS_q    <= '0;
      highS_q   <= '0;
      pending_q <= '0;
      outClk_q  <= '0;
      tick_q    <= '0;
    end else begin
      cnt_q     <= cnt_d;
      divA_q    <= divA_d;
      highA_q   <= highA_d;
      divS_q    <= divS_d;
      highS_q   <= highS_d;
      pending_q <= pending_d;
      outClk_q  <= outClk_d;
      tick_q    <= tick_d;
    end
  end

  assign out_clk_o = outClk_q;
  assign tick_o    = tick_q;
  assign pending_o = pending_q;

endmodule

// File: tb/tb_prescaler_multi.sv
// Directed bench for prescaler_multi (2 channels, 8-bit fields): expected
// out/tick/pending per cycle are queued as stimulus is driven and checked on the falling edge.
module tb_prescaler_multi;

  logic        clk = 1'b0;
  logic        rstN;
  logic [1:0]  en, load;
  logic [15:0] div, high;
  logic [1:0]  outClk, tick, pending;

  typedef struct {
    string      tag;
    logic [1:0] outE;
    logic [1:0] tickE;
    logic [1:0] pendE;
  } exp_t;

  exp_t sbQ[$];
  int   compareCount = 0;
  int   failCount    = 0;

  prescaler_multi #(
    .CHANNELS(2), .WIDTH(8), .RESET_DIV(1), .RESET_HIGH(1)
  ) dut (
    .clk_i    (clk),
    .rst_n_i  (rstN),
    .en_i     (en),
    .load_i   (load),
    .div_i    (div),
    .high_i   (high),
    .out_clk_o(outClk),
    .tick_o   (tick),
    .pending_o(pending)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [1:0] enV, input logic [1:0] loadV,
                               input logic [7:0] div0, input logic [7:0] high0,
                               input logic [7:0] div1, input logic [7:0] high1);
    en   = enV;
    load = loadV;
    div  = {div1, div0};
    high = {high1, high0};
  endtask

  task automatic pushExp(input string tag, input logic [1:0] o, input logic [1:0] t,
                         input logic [1:0] p);
    exp_t e;
    e.tag   = tag;
    e.outE  = o;
    e.tickE = t;
    e.pendE = p;
    sbQ.push_back(e);
  endtask

  task automatic compareHead();
    exp_t e;
    compareCount++;
    assert (sbQ.size() > 0) else begin
      failCount++;
      $error("[TB] FAIL scoreboard_empty observed size=0 expected size>0");
    end
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      compareCount += 3;
      assert (outClk === e.outE) else begin
        failCount++;
        $error("[TB] FAIL %s out_clk observed=%b expected=%b", e.tag, outClk, e.outE);
      end
      assert (tick === e.tickE) else begin
        failCount++;
        $error("[TB] FAIL %s tick observed=%b expected=%b", e.tag, tick, e.tickE);
      end
      assert (pending === e.pendE) else begin
        failCount++;
        $error("[TB] FAIL %s pending observed=%b expected=%b", e.tag, pending, e.pendE);
      end
    end
  endtask

  task automatic checkOutput();
    @(posedge clk);
    @(negedge clk);
    compareHead();
  endtask

  task automatic stepExpect(input string tag, input logic [1:0] o, input logic [1:0] t,
                            input logic [1:0] p);
    pushExp(tag, o, t, p);
    checkOutput();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstN = 1'b0;
    applyStimulus(2'b00, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0);
    stepExpect("reset", 2'b00, 2'b00, 2'b00);

    rstN = 1'b1;
    applyStimulus(2'b11, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0);
    for (int k = 0; k < 2; k++) begin
      stepExpect("div2_hi", 2'b11, 2'b11, 2'b00);
      stepExpect("div2_lo", 2'b00, 2'b00, 2'b00);
    end

    applyStimulus(2'b10, 2'b01, 8'd3, 8'd2, 8'd0, 8'd0);
    stepExpect("idle_load", 2'b10, 2'b10, 2'b00);
    applyStimulus(2'b11, 2'b00, 8'd3, 8'd2, 8'd0, 8'd0);
    for (int k = 0; k < 2; k++) begin
      stepExpect("div4_p0", 2'b01, 2'b01, 2'b00);
      stepExpect("div4_p1", 2'b11, 2'b10, 2'b00);
      stepExpect("div4_p2", 2'b00, 2'b00, 2'b00);
      stepExpect("div4_p3", 2'b10, 2'b10, 2'b00);
    end

    applyStimulus(2'b01, 2'b00, 8'd3, 8'd2, 8'd0, 8'd0);
    stepExpect("reload_p0", 2'b01, 2'b01, 2'b00);
    applyStimulus(2'b01, 2'b01, 8'd5, 8'd1, 8'd0, 8'd0);
    stepExpect("reload_p1", 2'b01, 2'b00, 2'b01);
    applyStimulus(2'b01, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0);
    stepExpect("reload_p2", 2'b00, 2'b00, 2'b01);
    stepExpect("reload_wrap", 2'b00, 2'b00, 2'b00);
    stepExpect("div6_p0", 2'b01, 2'b01, 2'b00);
    for (int k = 0; k < 5; k++) stepExpect("div6_low", 2'b00, 2'b00, 2'b00);
    stepExpect("div6_next", 2'b01, 2'b01, 2'b00);

    applyStimulus(2'b01, 2'b01, 8'd5, 8'd3, 8'd0, 8'd0);
    stepExpect("shadow_set", 2'b00, 2'b00, 2'b01);
    applyStimulus(2'b01, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0);
    for (int k = 0; k < 3; k++) stepExpect("shadow_hold", 2'b00, 2'b00, 2'b01);
    applyStimulus(2'b01, 2'b01, 8'd2, 8'd1, 8'd0, 8'd0);
    stepExpect("wrap_load", 2'b00, 2'b00, 2'b00);
    applyStimulus(2'b01, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0);
    stepExpect("div3_p0", 2'b01, 2'b01, 2'b00);
    stepExpect("div3_p1", 2'b00, 2'b00, 2'b00);
    stepExpect("div3_p2", 2'b00, 2'b00, 2'b00);
    stepExpect("div3_next", 2'b01, 2'b01, 2'b00);

    applyStimulus(2'b00, 2'b11, 8'd0, 8'd1, 8'd2, 8'd0);
    stepExpect("edge_load", 2'b00, 2'b00, 2'b00);
    applyStimulus(2'b11, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0);
    stepExpect("div0_high0_a", 2'b01, 2'b11, 2'b00);
    stepExpect("div0_high0_b", 2'b01, 2'b01, 2'b00);
    stepExpect("div0_high0_c", 2'b01, 2'b01, 2'b00);
    stepExpect("div0_high0_d", 2'b01, 2'b11, 2'b00);

    applyStimulus(2'b00, 2'b01, 8'd2, 8'd7, 8'd0, 8'd0);
    stepExpect("bighigh_load", 2'b00, 2'b00, 2'b00);
    applyStimulus(2'b01, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0);
    stepExpect("bighigh_p0", 2'b01, 2'b01, 2'b00);
    stepExpect("bighigh_p1", 2'b01, 2'b00, 2'b00);
    stepExpect("bighigh_p2", 2'b01, 2'b00, 2'b00);
    stepExpect("bighigh_next", 2'b01, 2'b01, 2'b00);

    applyStimulus(2'b01, 2'b01, 8'd4, 8'd2, 8'd0, 8'd0);
    stepExpect("pre_reset", 2'b01, 2'b00, 2'b01);
    applyStimulus(2'b01, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0);
    #2 rstN = 1'b0;
    #1 pushExp("async_reset", 2'b00, 2'b00, 2'b00);
    compareHead();
    stepExpect("reset_held", 2'b00, 2'b00, 2'b00);
    rstN = 1'b1;
    for (int k = 0; k < 2; k++) begin
      stepExpect("post_reset_hi", 2'b01, 2'b01, 2'b00);
      stepExpect("post_reset_lo", 2'b00, 2'b00, 2'b00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/prescaler_multi.md
# prescaler_multi

Multi-channel programmable clock prescaler, generalising the single-channel Prescaler. Each of `CHANNELS` independent channels divides `CLK` by a runtime-programmable ratio with a programmable high time, and emits a registered divided waveform plus a one-cycle period-start strobe. New divide settings load into a shadow register and are applied glitch-free at the next period boundary. The block sits between the system clock source and downstream timing logic as a bank of clock enables and waveforms.

## Interface
- `CHANNELS`, 2: number of independent channels (>=1)
- `WIDTH`, 8: width of per-channel DIV and HIGH fields
- `RESET_DIV`, 1: active DIV value after reset (divide by 2)
- `RESET_HIGH`, 1: active HIGH value after reset (50 % duty)

- `CLK`  in  1: single clock; all state changes on rising edge
- `RST_N`  in  1: reset, asynchronous, active-low; one clock, no other clocks or resets
- `EN`  in  CHANNELS: per-channel run enable
- `LOAD`  in  CHANNELS: per-channel one-cycle strobe capturing that channel's DIV/HIGH
- `DIV`  in  CHANNELS*WIDTH: channel i at bits [i*WIDTH +: WIDTH]; period = DIV+1 cycles
- `HIGH`  in  CHANNELS*WIDTH: channel i at bits [i*WIDTH +: WIDTH]; cycles OUT_CLK is high per period
- `OUT_CLK`  out  CHANNELS: registered divided waveform
- `TICK`  out  CHANNELS: registered one-cycle pulse on first cycle of each period
- `PENDING`  out  CHANNELS: shadow holds values not yet applied

## Operation
- Per channel state: phase counter `cnt` (WIDTH bits), active `div_a`/`high_a`, shadow `div_s`/`high_s`, pending flag.
- Reset (RST_N low, immediate): cnt=0, div_a=RESET_DIV, high_a=RESET_HIGH, shadows=0, PENDING=0, OUT_CLK=0, TICK=0.
- EN=0 at an edge: cnt<=0, OUT_CLK<=0, TICK<=0. LOAD while EN=0 writes div_a/high_a directly; PENDING stays 0.
- EN=1 at an edge, with p = current cnt:
  - OUT_CLK <= (p < high_a); TICK <= (p == 0)
  - cnt <= (p == div_a) ? 0 : p+1
- LOAD while EN=1 and not at wrap: DIV/HIGH captured into shadow, PENDING<=1. A later LOAD before wrap overwrites shadow.
- Wrap edge (EN=1, p==div_a): if PENDING, div_a/high_a <= shadow, PENDING<=0. If LOAD is asserted at the same edge, the LOAD values go straight to div_a/high_a (LOAD wins over the older shadow) and PENDING<=0.
- Comparisons are unsigned, WIDTH bits; no arithmetic beyond cnt+1, which never overflows because cnt <= div_a.
- Edge cases:
  - DIV=0: period 1, TICK constantly 1.
  - HIGH=0: OUT_CLK constantly 0.
  - HIGH > DIV: OUT_CLK constantly 1 while enabled.
- Channels are fully independent; no shared state.

## Timing
- Outputs are registered. The first edge with EN=1 gives TICK=1 and OUT_CLK=(high_a>0) immediately after that edge.
- Period is exactly div_a+1 cycles. OUT_CLK is high for min(high_a, div_a+1) cycles starting with the TICK cycle.
- A new setting affects the outputs starting with the first cycle of the following period. A partial period is never produced while EN stays high.
- EN falling: OUT_CLK and TICK are 0 after the next edge. The counter restarts at phase 0 when EN rises again.
- Reset mid-operation: outputs go to 0 asynchronously. After RST_N deasserts, the channel runs with RESET_DIV/RESET_HIGH, and any pending shadow is lost.

## Test plan
- Reset values, EN=1 on both channels: after reset, OUT_CLK toggles 1,0,1,0; TICK is high every 2nd cycle; PENDING=0.
- Basic divide: with EN=0, LOAD DIV=3 HIGH=2 on ch0, then set EN=1 -> OUT_CLK pattern 1,1,0,0 repeating, TICK on every 4th cycle aligned with the first 1; ch1 stays at divide-by-2.
- Mid-period reload: ch0 running DIV=3 HIGH=2; at phase 1, LOAD DIV=5 HIGH=1 -> PENDING=1 until the wrap; the current period completes as 1,1,0,0, then the pattern is 1,0,0,0,0,0; PENDING returns to 0 at the wrap.
- Edge cases:
  - DIV=0, HIGH=1 -> TICK and OUT_CLK constantly 1.
  - HIGH=0 -> OUT_CLK constantly 0, TICK still periodic.
  - DIV=2, HIGH=7 -> OUT_CLK constantly 1.
- Simultaneous LOAD and wrap: a pending shadow DIV=5 plus a LOAD of DIV=2 HIGH=1 at the wrap edge -> the next period is 3 cycles (1,0,0) and PENDING=0.
- Async reset mid-period: pull RST_N low between edges -> OUT_CLK, TICK and PENDING are 0 immediately without waiting for an edge; after release, the channel runs at divide-by-2.
